mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Parametrised successor to the pass-through MEM stage. It forwards ALU results to write-back and executes MIPS loads and stores on a request/acknowledge data-memory bus. Loads and stores take multiple cycles: the block raises a stall request to the pipeline controller until the access completes. It also absorbs the MEM/WB output register, flags misaligned accesses and times out hung bus cycles.

Parameters:
DATA_W, 32, datapath width (fixed at 32 for byte/half extraction; other values are illegal)
ADDR_W, 32, data-memory address width
REG_ADDR_W, 5, register-file address width
ACK_TIMEOUT, 255, maximum cycles spent in WAIT before abort (1..2^16-1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
valid_i  in  1  EX result valid this cycle
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  register write enable from EX
wdata_i  in  DATA_W  ALU result
memop_i  in  4  memory op code (package constants; MEM_NONE = pass-through)
mem_addr_i  in  ADDR_W  effective address
store_data_i  in  DATA_W  rt value for stores
wd_o  out  REG_ADDR_W  destination to WB
wreg_o  out  1  write enable to WB
wdata_o  out  DATA_W  write data to WB
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write
mem_addr_o  out  ADDR_W  word-aligned bus address (low two bits 0)
mem_sel_o  out  4  byte lanes; bit3 = bits 31:24
mem_wdata_o  out  DATA_W  store data, replicated into lanes
mem_rdata_i  in  DATA_W  load data
mem_ack_i  in  1  access complete, valid one cycle
stallreq_o  out  1  hold upstream pipeline
addr_err_o  out  1  one-cycle misalignment flag
bus_err_o  out  1  one-cycle timeout flag
badvaddr_o  out  ADDR_W  faulting address, valid with either error flag

Behaviour:
- Reset: all outputs are 0. State goes to IDLE and the timeout counter is cleared. Reset mid-WAIT drops mem_req_o the next cycle and produces no writeback.
- Byte order is big-endian: addr[1:0]=0 selects bits 31:24.
- IDLE, valid_i=0: next cycle wreg_o=0. wd_o and wdata_o keep their previous values.
- IDLE, valid_i with MEM_NONE: one-cycle latency. wd_o/wreg_o/wdata_o are loaded from the inputs. stallreq_o stays 0.
- Alignment: half-word ops need addr[0]=0; LW/SW need addr[1:0]=0.
- Misaligned op: no bus cycle. Next cycle addr_err_o=1, badvaddr_o=addr, wreg_o=0. Returns to IDLE.
- Aligned memory op in IDLE:
  - stallreq_o=1 combinationally in the accept cycle.
  - Next edge: state WAIT. mem_req_o=1 and mem_we_o=is_store. mem_addr_o, mem_sel_o and mem_wdata_o are registered; EX fields and op are latched.
  - Lane rules: SB sel=1000>>addr[1:0], data={4{b}}. SH sel=1100 (addr[1]=0) or 0011, data={2{h}}. SW sel=1111.
- WAIT: bus outputs are held stable until ack. valid_i is ignored; upstream holds its inputs because of the stall. stallreq_o=1 except in the ack cycle.
- WAIT, mem_ack_i=1: stallreq_o=0 that cycle (pipeline advances). Next edge:
  - mem_req_o=0; state IDLE.
  - Load: wdata_o = extracted lane. LB/LH sign-extend; LBU/LHU zero-extend. wreg_o=latched wreg. wd_o=latched wd.
  - Store: wreg_o=0.
- Timeout: the counter increments each WAIT cycle without ack.
  - On reaching ACK_TIMEOUT: mem_req_o drops; bus_err_o pulses with badvaddr_o=addr; wreg_o=0; stallreq_o=0; state IDLE.
  - Ack in the same cycle as the count reaching the limit: ack wins, no error.
- mem_ack_i while in IDLE is ignored.
- Throughput: one memory op per (2 + wait) cycles. Back-to-back memory ops are accepted in the cycle after returning to IDLE.

Decomposition:
- Package mem_pkg: memop codes (MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW), state enum {IDLE, WAIT}, and lane-select constants.
- Sub-module lsu_lane: combinational. Computes sel and store replication from op/addr, and load extract/extend from rdata/op/addr. It is reused in the WAIT path.

Test Plan:
- MEM_NONE, wd=5, wdata=0xDEADBEEF -> next cycle wd_o=5, wreg_o=1, wdata_o=0xDEADBEEF, stallreq_o never high.
- LB at addr 0x1001, rdata=0x12F45678, ack after 3 wait cycles:
  - bus side -> sel=0100, addr_o=0x1000.
  - writeback -> wdata_o=0xFFFFFFF4; stallreq_o high 4 cycles.
  - LBU variant -> 0x000000F4.
- SH at addr 0x2002, store_data=0x0000ABCD -> mem_we_o=1, sel=0011, mem_wdata_o=0xABCDABCD, wreg_o=0 after ack.
- LW at 0x3002 -> no mem_req_o; addr_err_o=1 one cycle, badvaddr_o=0x3002, wreg_o=0.
- ACK_TIMEOUT=4, no ack:
  - no ack ever -> bus_err_o after 4 WAIT cycles, mem_req_o low, returns IDLE.
  - ack at count 4 -> normal completion, no error.
- rst asserted during WAIT -> next cycle mem_req_o=0, stallreq_o=0, all outputs 0; late ack afterwards is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store MEM stage: memory op codes, FSM states,
// byte-lane select patterns and op classification helpers.
package mem_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic {S_IDLE, S_WAIT} lsu_state_t;

    // Big-endian lanes: bit 3 covers data bits 31:24 (address offset 0)
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return a[0];
        if (op inside {MEM_LW, MEM_SW})          return a != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational byte-lane logic: bus lane select and store replication from
// op/address, plus load lane extraction with sign or zero extension.
module lsu_lane
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        sel,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  bs;
        logic signed [31:0] r;
        bs = b;
        r  = bs;
        return sgn ? r : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] hs;
        logic signed [31:0] r;
        hs = h;
        r  = hs;
        return sgn ? r : {16'd0, h};
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        sel       = SEL_NONE;
        wdata     = store_data;
        load_data = rdata;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                sel       = SEL_B0 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = ext8(byte_lane, op == MEM_LB);
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                sel       = addr_lo[1] ? SEL_LO : SEL_HI;
                wdata     = {2{store_data[15:0]}};
                load_data = ext16(half_lane, op == MEM_LH);
            end
            MEM_LW, MEM_SW: sel = SEL_W;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage with load/store unit: forwards ALU results to WB, runs req/ack bus
// cycles for loads and stores, stalls the pipeline while busy, flags faults.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [3:0]            memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stallreq_o,
    output logic                  addr_err_o,
    output logic                  bus_err_o,
    output logic [ADDR_W-1:0]     badvaddr_o
);

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    lsu_state_t state, state_nxt;
    logic [15:0]           tmo_cnt_p1;
    logic [3:0]            op_p1;
    logic [REG_ADDR_W-1:0] wd_p1;
    logic                  wreg_p1;
    logic [ADDR_W-1:0]     addr_p1;

    logic [3:0]        lane_op;
    logic [1:0]        lane_addr;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;
    logic              accept, misalign, tmo_hit;

    // The lane block serves the incoming op in IDLE and the latched op in WAIT
    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .op         (lane_op),
        .addr_lo    (lane_addr),
        .store_data (store_data_i),
        .rdata      (mem_rdata_i),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        accept     = 1'b0;
        misalign   = 1'b0;
        tmo_hit    = 1'b0;
        lane_op    = memop_i;
        lane_addr  = mem_addr_i[1:0];
        case (state)
            S_IDLE: begin
                if (valid_i && is_mem(memop_i)) begin
                    if (is_misaligned(memop_i, mem_addr_i[1:0])) begin
                        misalign = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stallreq_o = 1'b1;
                        state_nxt  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                lane_op   = op_p1;
                lane_addr = addr_p1[1:0];
                // Ack in the limit cycle takes priority over the abort
                tmo_hit   = !mem_ack_i && (tmo_cnt_p1 == TMO_LAST);
                if (mem_ack_i || tmo_hit) state_nxt = S_IDLE;
                else                      stallreq_o = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) stallreq_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // p0 -> p1: outputs to WB and bus, timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_sel_o   <= '0;
            mem_wdata_o <= '0;
            addr_err_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            badvaddr_o  <= '0;
            tmo_cnt_p1  <= '0;
        end else begin
            addr_err_o <= 1'b0;
            bus_err_o  <= 1'b0;
            wreg_o     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i && !is_mem(memop_i)) begin
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i;
                        wdata_o <= wdata_i;
                    end
                    if (misalign) begin
                        addr_err_o <= 1'b1;
                        badvaddr_o <= mem_addr_i;
                    end
                    if (accept) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_store(memop_i);
                        mem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        mem_sel_o   <= lane_sel;
                        mem_wdata_o <= lane_wdata;
                        tmo_cnt_p1  <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (is_load(op_p1)) begin
                            wd_o    <= wd_p1;
                            wreg_o  <= wreg_p1;
                            wdata_o <= lane_load;
                        end
                    end else if (tmo_hit) begin
                        mem_req_o  <= 1'b0;
                        bus_err_o  <= 1'b1;
                        badvaddr_o <= addr_p1;
                    end else begin
                        tmo_cnt_p1 <= tmo_cnt_p1 + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1   <= memop_i;
            wd_p1   <= wd_i;
            wreg_p1 <= wreg_i;
            addr_p1 <= mem_addr_i;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level expectation model checked
// every cycle, plus literal checks on the hand-computed cases.
module tb_mem_lsu;
    import mem_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int RW  = 5;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid_i, wreg_i, mem_ack_i;
    logic [RW-1:0] wd_i;
    logic [DW-1:0] wdata_i, store_data_i, mem_rdata_i;
    logic [3:0]    memop_i;
    logic [AW-1:0] mem_addr_i;

    logic [RW-1:0] wd_o;
    logic          wreg_o, mem_req_o, mem_we_o, stallreq_o, addr_err_o, bus_err_o;
    logic [DW-1:0] wdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o, badvaddr_o;
    logic [3:0]    mem_sel_o;

    mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .memop_i(memop_i), .mem_addr_i(mem_addr_i),
        .store_data_i(store_data_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .stallreq_o(stallreq_o), .addr_err_o(addr_err_o),
        .bus_err_o(bus_err_o), .badvaddr_o(badvaddr_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int s0;
    bit chk_on = 1'b0;

    logic [RW-1:0] e_wd;
    logic          e_wreg, e_req, e_we, e_stall, e_aerr, e_berr;
    logic [DW-1:0] e_wdata, e_mwdata;
    logic [AW-1:0] e_addr, e_badv;
    logic [3:0]    e_sel;

    logic [3:0]    cap_sel;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_mwdata;
    logic          cap_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation model: access size, big-endian lane position, replication, extension
    function automatic int m_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
        int sz;
        sz = m_size(op);
        return 4'(((1 << sz) - 1) << (4 - sz - int'(a[1:0])));
    endfunction

    function automatic logic [31:0] m_repl(input logic [3:0] op, input logic [31:0] d);
        case (m_size(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r);
        int sz, sh;
        logic [31:0] mask, v;
        sz   = m_size(op);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        sh   = 8 * (4 - sz - int'(a[1:0]));
        v    = (r >> sh) & mask;
        if ((op == MEM_LB || op == MEM_LH) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_is_store(input logic [3:0] op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stallreq", 32'(stallreq_o), 32'(e_stall));
            chk("wreg", 32'(wreg_o), 32'(e_wreg));
            chk("wd", 32'(wd_o), 32'(e_wd));
            chk("wdata", wdata_o, e_wdata);
            chk("mem_req", 32'(mem_req_o), 32'(e_req));
            chk("addr_err", 32'(addr_err_o), 32'(e_aerr));
            chk("bus_err", 32'(bus_err_o), 32'(e_berr));
            if (e_req) begin
                chk("mem_we", 32'(mem_we_o), 32'(e_we));
                chk("mem_addr", mem_addr_o, e_addr);
                chk("mem_sel", 32'(mem_sel_o), 32'(e_sel));
                if (e_we) chk("mem_wdata", mem_wdata_o, e_mwdata);
            end
            if (e_aerr || e_berr) chk("badvaddr", badvaddr_o, e_badv);
            if (stallreq_o) stall_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        e_aerr = 1'b0;
        e_berr = 1'b0;
    endtask

    task automatic idle(input logic ack);
        valid_i = 1'b0; mem_ack_i = ack; e_stall = 1'b0;
        cyc();
        mem_ack_i = 1'b0;
        e_wreg = 1'b0;
    endtask

    task automatic passthru(input logic [RW-1:0] wd, input logic wr, input logic [31:0] d);
        valid_i = 1'b1; memop_i = MEM_NONE; wd_i = wd; wreg_i = wr; wdata_i = d;
        e_stall = 1'b0;
        cyc();
        valid_i = 1'b0;
        e_wd = wd; e_wreg = wr; e_wdata = d;
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] a);
        valid_i = 1'b1; memop_i = op; mem_addr_i = a; wreg_i = 1'b1; wd_i = 5'd30;
        e_stall = 1'b0;
        cyc();
        valid_i = 1'b0;
        e_wreg = 1'b0; e_aerr = 1'b1; e_badv = a;
    endtask

    task automatic accept_op(input logic [3:0] op, input logic [RW-1:0] wd, input logic [31:0] a,
                             input logic [31:0] sd);
        valid_i = 1'b1; memop_i = op; wd_i = wd; wreg_i = 1'b1; wdata_i = 32'h5555_0000 ^ a;
        mem_addr_i = a; store_data_i = sd; mem_rdata_i = '0;
        e_stall = 1'b1;
        cyc();
        e_req = 1'b1; e_we = m_is_store(op); e_addr = {a[31:2], 2'b00};
        e_sel = m_sel(op, a); e_mwdata = m_repl(op, sd); e_wreg = 1'b0;
        cap_sel = mem_sel_o; cap_addr = mem_addr_o; cap_mwdata = mem_wdata_o; cap_we = mem_we_o;
    endtask

    // nwait cycles of WAIT without ack, then ack (do_ack) or run into the timeout
    task automatic mem_op(input logic [3:0] op, input logic [RW-1:0] wd, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int nwait, input bit do_ack);
        accept_op(op, wd, a, sd);
        for (int k = 1; k <= TMO; k++) begin
            if (do_ack && k == nwait + 1) begin
                mem_ack_i = 1'b1; mem_rdata_i = rd; e_stall = 1'b0;
                cyc();
                mem_ack_i = 1'b0; mem_rdata_i = '0; valid_i = 1'b0; e_req = 1'b0;
                if (!m_is_store(op)) begin
                    e_wreg = 1'b1; e_wd = wd; e_wdata = m_load(op, a, rd);
                end
                break;
            end else if (k == TMO) begin
                e_stall = 1'b0;
                cyc();
                valid_i = 1'b0; e_req = 1'b0; e_berr = 1'b1; e_badv = a;
                break;
            end else begin
                e_stall = 1'b1;
                cyc();
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wd"}, 32'(wd_o), 32'd0);
        chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_maddr"}, mem_addr_o, 32'd0);
        chk({tag, "_sel"}, 32'(mem_sel_o), 32'd0);
        chk({tag, "_mwdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        chk({tag, "_aerr"}, 32'(addr_err_o), 32'd0);
        chk({tag, "_berr"}, 32'(bus_err_o), 32'd0);
        chk({tag, "_badv"}, badvaddr_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; memop_i = MEM_NONE;
        mem_addr_i = '0; store_data_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        e_wd = '0; e_wreg = 1'b0; e_wdata = '0; e_req = 1'b0; e_we = 1'b0; e_addr = '0;
        e_sel = '0; e_mwdata = '0; e_stall = 1'b0; e_aerr = 1'b0; e_berr = 1'b0; e_badv = '0;
        cyc();
        cyc();
        check_all_zero("reset");
        chk_on = 1'b1;
        rst = 1'b0;

        s0 = stall_cnt;
        passthru(5'd5, 1'b1, 32'hDEAD_BEEF);
        chk("pt_wd", 32'(wd_o), 32'd5);
        chk("pt_wreg", 32'(wreg_o), 32'd1);
        chk("pt_wdata", wdata_o, 32'hDEAD_BEEF);
        idle(1'b0);
        chk("pt_idle_wreg", 32'(wreg_o), 32'd0);
        chk("pt_idle_wdata_hold", wdata_o, 32'hDEAD_BEEF);
        chk("pt_stall_cycles", 32'(stall_cnt - s0), 32'd0);

        s0 = stall_cnt;
        mem_op(MEM_LB, 5'd7, 32'h1001, 32'h0, 32'h12F4_5678, 3, 1'b1);
        chk("lb_sel", 32'(cap_sel), 32'h4);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_wdata", wdata_o, 32'hFFFF_FFF4);
        chk("lb_wreg", 32'(wreg_o), 32'd1);
        chk("lb_wd", 32'(wd_o), 32'd7);
        chk("lb_no_berr", 32'(bus_err_o), 32'd0);
        chk("lb_stall_cycles", 32'(stall_cnt - s0), 32'd4);

        mem_op(MEM_LBU, 5'd8, 32'h1001, 32'h0, 32'h12F4_5678, 1, 1'b1);
        chk("lbu_wdata", wdata_o, 32'h0000_00F4);

        mem_op(MEM_SH, 5'd9, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 1'b1);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_sel", 32'(cap_sel), 32'h3);
        chk("sh_mwdata", cap_mwdata, 32'hABCD_ABCD);
        chk("sh_wreg", 32'(wreg_o), 32'd0);
        idle(1'b0);

        misaligned(MEM_LW, 32'h3002);
        chk("lw_mis_aerr", 32'(addr_err_o), 32'd1);
        chk("lw_mis_badv", badvaddr_o, 32'h3002);
        chk("lw_mis_wreg", 32'(wreg_o), 32'd0);
        chk("lw_mis_req", 32'(mem_req_o), 32'd0);
        idle(1'b0);
        chk("lw_mis_pulse", 32'(addr_err_o), 32'd0);
        misaligned(MEM_LH, 32'h1001);
        misaligned(MEM_SW, 32'h2001);
        misaligned(MEM_SH, 32'h2003);
        idle(1'b0);

        mem_op(MEM_LW, 5'd1, 32'h4000, 32'h0, 32'h89AB_CDEF, 0, 1'b1);
        chk("lw_wdata", wdata_o, 32'h89AB_CDEF);
        mem_op(MEM_LH, 5'd2, 32'h4002, 32'h0, 32'h1234_8001, 2, 1'b1);
        chk("lh_wdata", wdata_o, 32'hFFFF_8001);
        mem_op(MEM_LHU, 5'd3, 32'h4000, 32'h0, 32'h8001_1234, 1, 1'b1);
        chk("lhu_wdata", wdata_o, 32'h0000_8001);
        mem_op(MEM_SB, 5'd4, 32'h5003, 32'h1234_565A, 32'h0, 1, 1'b1);
        chk("sb_sel", 32'(cap_sel), 32'h1);
        chk("sb_mwdata", cap_mwdata, 32'h5A5A_5A5A);
        mem_op(MEM_SW, 5'd6, 32'h6000, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
        chk("sw_mwdata", cap_mwdata, 32'hCAFE_F00D);
        chk("sw_sel", 32'(cap_sel), 32'hF);

        s0 = stall_cnt;
        mem_op(MEM_LW, 5'd10, 32'h7000, 32'h0, 32'h0, 0, 1'b0);
        chk("tmo_berr", 32'(bus_err_o), 32'd1);
        chk("tmo_badv", badvaddr_o, 32'h7000);
        chk("tmo_req", 32'(mem_req_o), 32'd0);
        chk("tmo_wreg", 32'(wreg_o), 32'd0);
        chk("tmo_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        idle(1'b0);
        chk("tmo_pulse", 32'(bus_err_o), 32'd0);
        passthru(5'd3, 1'b1, 32'h1111_1111);
        chk("tmo_back_idle", wdata_o, 32'h1111_1111);

        mem_op(MEM_LW, 5'd11, 32'h7004, 32'h0, 32'hA5A5_A5A5, 3, 1'b1);
        chk("limit_ack_berr", 32'(bus_err_o), 32'd0);
        chk("limit_ack_wdata", wdata_o, 32'hA5A5_A5A5);

        idle(1'b1);
        chk("idle_ack_wreg", 32'(wreg_o), 32'd0);
        chk("idle_ack_req", 32'(mem_req_o), 32'd0);

        accept_op(MEM_LW, 5'd12, 32'h8000, 32'h0);
        e_stall = 1'b1;
        cyc();
        rst = 1'b1; valid_i = 1'b0; e_stall = 1'b0;
        cyc();
        rst = 1'b0;
        e_wd = '0; e_wreg = 1'b0; e_wdata = '0; e_req = 1'b0; e_badv = '0;
        check_all_zero("rst_wait");
        idle(1'b1);
        chk("late_ack_wreg", 32'(wreg_o), 32'd0);
        chk("late_ack_wdata", wdata_o, 32'd0);
        idle(1'b0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
